// File: rtl/fp_issue_ctrl.sv
// Issue/writeback sequencer for a combinational FPU: latches one request, waits the
// op-dependent latency, captures the result and holds it until the writeback side takes it.
module fp_issue_ctrl #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LAT_ADDSUB = 2,
  parameter int unsigned LAT_MUL    = 3,
  parameter int unsigned LAT_DIV    = 8,
  parameter int unsigned LAT_OTHER  = 1
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_req_valid,
  output logic                  out_req_ready,
  input  logic [DATA_WIDTH-1:0] in_rs1,
  input  logic [DATA_WIDTH-1:0] in_rs2,
  input  logic [3:0]            in_FPU_Op,
  input  logic                  in_fmt,
  input  logic                  in_output_fmt,
  input  logic [4:0]            in_rd,
  output logic [DATA_WIDTH-1:0] out_fpu_rs1,
  output logic [DATA_WIDTH-1:0] out_fpu_rs2,
  output logic [3:0]            out_fpu_op,
  output logic                  out_fpu_fmt,
  output logic                  out_fpu_output_fmt,
  input  logic [DATA_WIDTH-1:0] in_fpu_data,
  output logic                  out_wb_valid,
  input  logic                  in_wb_ready,
  output logic [DATA_WIDTH-1:0] out_wb_data,
  output logic [4:0]            out_wb_rd,
  output logic                  out_wb_illegal,
  output logic                  out_busy
);

  localparam int unsigned MAX_AM  = (LAT_ADDSUB > LAT_MUL) ? LAT_ADDSUB : LAT_MUL;
  localparam int unsigned MAX_DO  = (LAT_DIV > LAT_OTHER) ? LAT_DIV : LAT_OTHER;
  localparam int unsigned MAX_LAT = (MAX_AM > MAX_DO) ? MAX_AM : MAX_DO;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [4:0]       rd_q;
  logic             accept;
  logic             finish;

  // Counter is loaded with LAT-1 so that EXEC lasts exactly LAT edges.
  function automatic logic [CNT_W-1:0] lat_m1(input logic [3:0] op);
    case (op)
      4'b0000: lat_m1 = CNT_W'(LAT_ADDSUB - 1);
      4'b0001: lat_m1 = CNT_W'(LAT_MUL - 1);
      4'b0010: lat_m1 = CNT_W'(LAT_DIV - 1);
      default: lat_m1 = CNT_W'(LAT_OTHER - 1);
    endcase
  endfunction

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    accept        = 1'b0;
    finish        = 1'b0;
    out_req_ready = 1'b0;
    case (state)
      IDLE: begin
        out_req_ready = 1'b1;
        accept        = in_req_valid;
      end
      EXEC: begin
        if (cnt == '0) begin
          finish     = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        out_req_ready = in_wb_ready;
        if (in_wb_ready) begin
          if (in_req_valid) accept = 1'b1;
          else              state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // A DONE-state accept retires the current result and starts the next op on one edge.
    if (accept) begin
      state_next = EXEC;
      cnt_next   = lat_m1(in_FPU_Op);
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state              <= IDLE;
      cnt                <= '0;
      rd_q               <= '0;
      out_fpu_rs1        <= '0;
      out_fpu_rs2        <= '0;
      out_fpu_op         <= '0;
      out_fpu_fmt        <= 1'b0;
      out_fpu_output_fmt <= 1'b0;
      out_wb_data        <= '0;
      out_wb_rd          <= '0;
      out_wb_illegal     <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        out_fpu_rs1        <= in_rs1;
        out_fpu_rs2        <= in_rs2;
        out_fpu_op         <= in_FPU_Op;
        out_fpu_fmt        <= in_fmt;
        out_fpu_output_fmt <= in_output_fmt;
        rd_q               <= in_rd;
      end
      if (finish) begin
        out_wb_data    <= in_fpu_data;
        out_wb_rd      <= rd_q;
        out_wb_illegal <= out_fpu_op[3];
      end
    end
  end

  assign out_wb_valid = (state == DONE);
  assign out_busy     = (state != IDLE);

endmodule
